// File: rtl/ifft_twiddle_sequencer.sv
// Twiddle-ROM address sequencer for one radix-2 IFFT frame: issue stage -> ROM -> present stage.
// Optional stall counter output enabled by defining TW_SEQ_STALL_CNT_EN.
module ifft_twiddle_sequencer #(
  parameter int N_LOG2 = 5,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic                tw_valid,
  input  logic                tw_ready,
  output logic [2:0]          tw_stage,
  output logic [N_LOG2-2:0]   tw_bf,
  output logic                tw_last
`ifdef TW_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int BF_W = N_LOG2 - 1;
  localparam int AW1  = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_next;
  logic              issue_v;
  logic [2:0]        issue_stage;
  logic [BF_W-1:0]   issue_bf;
  logic              adv;
  logic              issue_is_last;
  logic              start_ok;
  logic              accept_last;
  logic [2:0]        nxt_stage;
  logic [BF_W-1:0]   nxt_bf;

  // Stage s uses the 2^s twiddles stored from offset 2^s - 1.
  function automatic logic [ADDR_W-1:0] tw_addr(input logic [2:0] s, input logic [BF_W-1:0] j);
    logic [AW1-1:0] base;
    logic [AW1-1:0] k;
    base = (AW1'(1) << s) - AW1'(1);
    k    = AW1'(j) & base;
    return ADDR_W'(base + k);
  endfunction

  assign adv           = !tw_valid || tw_ready;
  assign issue_is_last = (issue_stage == 3'(N_LOG2 - 1)) && (issue_bf == '1);
  assign start_ok      = (state == IDLE) && start && !abort;
  assign accept_last   = tw_valid && tw_ready && tw_last;
  assign busy          = (state != IDLE);
  assign nxt_bf        = issue_bf + BF_W'(1);
  assign nxt_stage     = (issue_bf == '1) ? issue_stage + 3'd1 : issue_stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = RUN;
        RUN:     if (adv && issue_is_last) state_next = DRAIN;
        DRAIN:   if (accept_last) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_v     <= 1'b0;
      issue_stage <= '0;
      issue_bf    <= '0;
      rom_addr    <= '0;
      tw_valid    <= 1'b0;
      tw_stage    <= '0;
      tw_bf       <= '0;
      tw_last     <= 1'b0;
      done        <= 1'b0;
    end else if (abort) begin
      issue_v     <= 1'b0;
      issue_stage <= '0;
      issue_bf    <= '0;
      rom_addr    <= '0;
      tw_valid    <= 1'b0;
      tw_stage    <= '0;
      tw_bf       <= '0;
      tw_last     <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= (state == DRAIN) && accept_last;
      // Under stall everything holds, so the ROM keeps re-reading the same address.
      if (adv) begin
        tw_valid <= issue_v;
        tw_stage <= issue_stage;
        tw_bf    <= issue_bf;
        tw_last  <= issue_v && issue_is_last;
        if (state == RUN && !issue_is_last) begin
          issue_stage <= nxt_stage;
          issue_bf    <= nxt_bf;
          rom_addr    <= tw_addr(nxt_stage, nxt_bf);
        end else begin
          issue_v <= 1'b0;
        end
      end
      if (start_ok) begin
        issue_v     <= 1'b1;
        issue_stage <= '0;
        issue_bf    <= '0;
        rom_addr    <= tw_addr(3'd0, '0);
      end
    end
  end

`ifdef TW_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (start_ok)
      stall_cnt <= '0;
    else if (tw_valid && !tw_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
